branch_cond_unit: RTL and testbench

//  Consumer of the ALU status interface (negative, zero, overflow, carry_out).

---
 rtl/branch_cond_unit.sv | 180 ++++++++++++++++++
 tb/tb_branch_cond_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// ---------------------------------------------------------------------------------------------
// branch_cond_unit
//
// Owns the architectural NZVC flag register and resolves ID-stage branches for the fetch stage.
// Flag-setting EX instructions (ADDS/SUBS/ANDS) load the register at the next edge. A branch
// presented in ID is resolved into a registered one-cycle br_done pulse with br_taken.
//
// The EX->ID flag hazard (B.cond in ID while EX sets flags) is handled two ways:
//   FORWARD = 1 : the EX flags are bypassed into the same-cycle evaluation, latency 1.
//   FORWARD = 0 : stall is raised for one cycle, the condition code is latched, and the
//                 branch is evaluated one cycle later against the updated register, latency 2.
//
// Parameters
//   BITS         width of the CBZ/CBNZ operand
//   FORWARD      1 = bypass EX flags, 0 = stall one cycle on the hazard
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        synchronous active-high reset
//   ex_set_flags EX instruction is valid and writes the flags
//   ex_negative  EX ALU N flag
//   ex_zero      EX ALU Z flag
//   ex_overflow  EX ALU V flag
//   ex_carry_out EX ALU C flag
//   br_valid     ID presents a branch this cycle
//   br_type      00 B, 01 CBZ, 10 CBNZ, 11 B.cond
//   br_cond      B.cond condition code
//   cbz_data     register operand for CBZ/CBNZ
//   flush        kill any pending or outgoing resolution
//   flags        registered {N,Z,V,C}
//   stall        combinational, hold ID/IF this cycle
//   br_done      registered one-cycle pulse, resolution valid
//   br_taken     registered, meaningful while br_done is high
// ---------------------------------------------------------------------------------------------

module branch_cond_unit #(
    parameter int unsigned BITS    = 64,
    parameter bit          FORWARD = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_set_flags,
    input  logic            ex_negative,
    input  logic            ex_zero,
    input  logic            ex_overflow,
    input  logic            ex_carry_out,
    input  logic            br_valid,
    input  logic [1:0]      br_type,
    input  logic [3:0]      br_cond,
    input  logic [BITS-1:0] cbz_data,
    input  logic            flush,
    output logic [3:0]      flags,
    output logic            stall,
    output logic            br_done,
    output logic            br_taken
);

    localparam logic [1:0] BrUncond = 2'b00;
    localparam logic [1:0] BrCbz    = 2'b01;
    localparam logic [1:0] BrCbnz   = 2'b10;
    localparam logic [1:0] BrCond   = 2'b11;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } state_t;

    state_t      state_q;
    logic [3:0]  flags_q;
    logic [3:0]  cond_q;
    logic        br_done_q;
    logic        br_taken_q;

    logic [3:0]  ex_flags;
    logic        hazard;
    logic        hold_for_flags;
    logic [3:0]  eval_flags;
    logic        idle_taken;
    logic        wait_taken;

    // Condition codes come in pairs: the upper three bits pick a base test and bit 0 inverts
    // it. Codes E and F are both "always" and must not be inverted.
    function automatic logic cond_holds(input logic [3:0] code, input logic [3:0] f);
        logic n;
        logic z;
        logic v;
        logic c;
        logic base;
        {n, z, v, c} = f;
        case (code[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (code[3:1] == 3'd7) ? 1'b1 : (base ^ code[0]);
    endfunction

    function automatic logic branch_taken(input logic [1:0]      kind,
                                          input logic [3:0]      code,
                                          input logic [BITS-1:0] data,
                                          input logic [3:0]      f);
        logic t;
        case (kind)
            BrUncond: t = 1'b1;
            BrCbz:    t = (data == '0);
            BrCbnz:   t = (data != '0);
            BrCond:   t = cond_holds(code, f);
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

    always_comb begin
        ex_flags       = {ex_negative, ex_zero, ex_overflow, ex_carry_out};
        // Only B.cond reads flags, so CBZ/CBNZ/B never see the hazard.
        hazard         = br_valid & (br_type == BrCond) & ex_set_flags;
        hold_for_flags = hazard & ~FORWARD;
        eval_flags     = (hazard & FORWARD) ? ex_flags : flags_q;
        idle_taken     = branch_taken(br_type, br_cond, cbz_data, eval_flags);
        // In WAIT the register already holds the flags written by the EX instruction.
        wait_taken     = cond_holds(cond_q, flags_q);
    end

    assign stall = ~reset & ~flush & (state_q == StIdle) & hold_for_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            flags_q    <= 4'b0000;
            cond_q     <= 4'b0000;
            br_done_q  <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            // Flag writes are architectural and unaffected by flush.
            if (ex_set_flags) begin
                flags_q <= ex_flags;
            end

            if (flush) begin
                state_q   <= StIdle;
                br_done_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (hold_for_flags) begin
                            cond_q    <= br_cond;
                            state_q   <= StWait;
                            br_done_q <= 1'b0;
                        end else if (br_valid) begin
                            br_done_q  <= 1'b1;
                            br_taken_q <= idle_taken;
                        end else begin
                            br_done_q <= 1'b0;
                        end
                    end
                    StWait: begin
                        // ID inputs are the held copy of the stalled branch; ignore them.
                        br_done_q  <= 1'b1;
                        br_taken_q <= wait_taken;
                        state_q    <= StIdle;
                    end
                    default: begin
                        state_q   <= StIdle;
                        br_done_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign flags    = flags_q;
    assign br_done  = br_done_q;
    assign br_taken = br_taken_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: two instances (FORWARD=0 and FORWARD=1) share one stimulus and
// are compared every cycle against a behavioural model, plus table vectors and hand sequences.

module tb_branch_cond_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ex_set_flags;
    logic        ex_negative;
    logic        ex_zero;
    logic        ex_overflow;
    logic        ex_carry_out;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [3:0]  br_cond;
    logic [63:0] cbz_data;
    logic        flush;

    logic [3:0]  flags_s, flags_f;
    logic        stall_s, stall_f;
    logic        done_s, done_f;
    logic        taken_s, taken_f;

    int tests = 0;
    int fails = 0;

    branch_cond_unit #(.BITS(64), .FORWARD(1'b0)) dut_s (
        .clk(clk), .reset(reset), .ex_set_flags(ex_set_flags), .ex_negative(ex_negative),
        .ex_zero(ex_zero), .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out),
        .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond), .cbz_data(cbz_data),
        .flush(flush), .flags(flags_s), .stall(stall_s), .br_done(done_s), .br_taken(taken_s)
    );

    branch_cond_unit #(.BITS(64), .FORWARD(1'b1)) dut_f (
        .clk(clk), .reset(reset), .ex_set_flags(ex_set_flags), .ex_negative(ex_negative),
        .ex_zero(ex_zero), .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out),
        .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond), .cbz_data(cbz_data),
        .flush(flush), .flags(flags_f), .stall(stall_f), .br_done(done_f), .br_taken(taken_f)
    );

    // Model state, index 0 = FORWARD 0, index 1 = FORWARD 1.
    bit [3:0] m_flags[2];
    bit       m_pend[2];
    bit [3:0] m_cond[2];
    bit       m_done[2];
    bit       m_taken[2];

    function automatic bit ref_cond(input logic [3:0] code, input logic [3:0] f);
        bit n, z, v, c;
        n = f[3]; z = f[2]; v = f[1]; c = f[0];
        case (code)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit ref_taken(input logic [1:0] t, input logic [3:0] c,
                                     input logic [63:0] d, input logic [3:0] f);
        case (t)
            2'd0: return 1'b1;
            2'd1: return d == 64'd0;
            2'd2: return d != 64'd0;
            default: return ref_cond(c, f);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit hazard_now();
        return br_valid && br_type == 2'd3 && ex_set_flags;
    endfunction

    task automatic model_next();
        logic [3:0] exf;
        exf = {ex_negative, ex_zero, ex_overflow, ex_carry_out};
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_flags[i] = 4'd0; m_pend[i] = 0; m_done[i] = 0; m_taken[i] = 0;
            end else begin
                if (flush) begin
                    m_pend[i] = 0;
                    m_done[i] = 0;
                end else if (m_pend[i]) begin
                    m_done[i]  = 1;
                    m_taken[i] = ref_cond(m_cond[i], m_flags[i]);
                    m_pend[i]  = 0;
                end else if (br_valid) begin
                    if (hazard_now() && i == 0) begin
                        m_pend[i] = 1;
                        m_cond[i] = br_cond;
                        m_done[i] = 0;
                    end else begin
                        m_done[i]  = 1;
                        m_taken[i] = ref_taken(br_type, br_cond, cbz_data,
                                               hazard_now() ? exf : m_flags[i]);
                    end
                end else begin
                    m_done[i] = 0;
                end
                if (ex_set_flags) m_flags[i] = exf;
            end
        end
    endtask

    // One clock: check stall on settled inputs, advance model, check registered outputs.
    task automatic step();
        #1;
        check("stall_fwd0", stall_s, !reset && !flush && !m_pend[0] && hazard_now());
        check("stall_fwd1", stall_f, 1'b0);
        model_next();
        @(posedge clk);
        #1;
        check("flags_fwd0", flags_s, m_flags[0]);
        check("flags_fwd1", flags_f, m_flags[1]);
        check("done_fwd0", done_s, m_done[0]);
        check("done_fwd1", done_f, m_done[1]);
        check("taken_fwd0", taken_s, m_taken[0]);
        check("taken_fwd1", taken_f, m_taken[1]);
    endtask

    task automatic idle_inputs();
        reset = 0; flush = 0; ex_set_flags = 0; br_valid = 0; br_type = 0; br_cond = 0;
        cbz_data = 0; {ex_negative, ex_zero, ex_overflow, ex_carry_out} = 4'd0;
    endtask

    task automatic load_flags(input logic [3:0] f);
        ex_set_flags = 1;
        {ex_negative, ex_zero, ex_overflow, ex_carry_out} = f;
        step();
        ex_set_flags = 0;
    endtask

    task automatic branch(input logic [1:0] t, input logic [3:0] c, input logic [63:0] d);
        br_valid = 1; br_type = t; br_cond = c; cbz_data = d;
        step();
        br_valid = 0;
    endtask

    typedef struct {
        logic [3:0]  f;
        logic [1:0]  t;
        logic [3:0]  c;
        logic [63:0] d;
        logic        exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{4'b1001, 2'd3, 4'hB, 64'd0, 1'b1};   // LT, N!=V
        vecs[1]  = '{4'b1001, 2'd3, 4'hA, 64'd0, 1'b0};   // GE
        vecs[2]  = '{4'b0100, 2'd3, 4'h0, 64'd0, 1'b1};   // EQ
        vecs[3]  = '{4'b0001, 2'd3, 4'h8, 64'd0, 1'b1};   // HI
        vecs[4]  = '{4'b0101, 2'd3, 4'h9, 64'd0, 1'b1};   // LS with Z
        vecs[5]  = '{4'b0100, 2'd3, 4'hD, 64'd0, 1'b1};   // LE with Z
        vecs[6]  = '{4'b1010, 2'd3, 4'hC, 64'd0, 1'b1};   // GT, N==V
        vecs[7]  = '{4'b0000, 2'd3, 4'h6, 64'd0, 1'b0};   // VS
        vecs[8]  = '{4'b0000, 2'd3, 4'hF, 64'd0, 1'b1};   // always
        vecs[9]  = '{4'b0000, 2'd1, 4'h0, 64'h8000_0000_0000_0000, 1'b0}; // CBZ nonzero
        vecs[10] = '{4'b0000, 2'd2, 4'h0, 64'h8000_0000_0000_0000, 1'b1}; // CBNZ nonzero
        vecs[11] = '{4'b0100, 2'd0, 4'h1, 64'd5, 1'b1};   // B ignores cond

        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;

        // Flag load then LT/GE.
        load_flags(4'b1001);
        check("flag_load", flags_f, 4'b1001);
        branch(2'd3, 4'hB, 64'd0);
        check("lt_done", done_f, 1'b1);
        check("lt_taken", taken_f, 1'b1);
        branch(2'd3, 4'hA, 64'd0);
        check("ge_taken", taken_s, 1'b0);

        for (int i = 0; i < 12; i++) begin
            load_flags(vecs[i].f);
            branch(vecs[i].t, vecs[i].c, vecs[i].d);
            check($sformatf("vec%0d_done", i), done_s, 1'b1);
            check($sformatf("vec%0d_taken_fwd0", i), taken_s, vecs[i].exp);
            check($sformatf("vec%0d_taken_fwd1", i), taken_f, vecs[i].exp);
        end

        // Hazard: bypass versus one-cycle stall.
        load_flags(4'b0000);
        ex_set_flags = 1; ex_zero = 1; br_valid = 1; br_type = 2'd3; br_cond = 4'h0;
        #1;
        check("haz_stall_fwd1", stall_f, 1'b0);
        check("haz_stall_fwd0", stall_s, 1'b1);
        step();
        check("haz_t1_done_fwd1", done_f, 1'b1);
        check("haz_t1_taken_fwd1", taken_f, 1'b1);
        check("haz_t1_done_fwd0", done_s, 1'b0);
        idle_inputs();
        #1;
        check("haz_wait_stall", stall_s, 1'b0);
        step();
        check("haz_t2_done_fwd0", done_s, 1'b1);
        check("haz_t2_taken_fwd0", taken_s, 1'b1);

        // CBZ/CBNZ never stall even with a flag write in EX.
        ex_set_flags = 1;
        br_valid = 1; br_type = 2'd1; cbz_data = 64'd0;
        #1;
        check("cbz_nostall", stall_s, 1'b0);
        step();
        check("cbz_zero_taken", taken_s, 1'b1);
        br_type = 2'd2; cbz_data = 64'h8000_0000_0000_0000;
        step();
        check("cbnz_taken", taken_s, 1'b1);
        idle_inputs();

        // Flush in WAIT.
        load_flags(4'b0000);
        ex_set_flags = 1; ex_zero = 1; br_valid = 1; br_type = 2'd3; br_cond = 4'h1;
        step();
        ex_set_flags = 0; flush = 1;
        step();
        check("flush_no_done", done_s, 1'b0);
        idle_inputs();
        branch(2'd0, 4'h0, 64'd0);
        check("flush_back_idle", done_s, 1'b1);

        // Reset mid-WAIT.
        load_flags(4'b1111);
        ex_set_flags = 1; br_valid = 1; br_type = 2'd3; br_cond = 4'h4;
        step();
        idle_inputs();
        reset = 1;
        step();
        check("rst_stall", stall_s, 1'b0);
        step();
        check("rst_flags", flags_s, 4'd0);
        check("rst_done", done_s, 1'b0);
        reset = 0;
        branch(2'd0, 4'h0, 64'd0);
        check("rst_back_idle", done_s, 1'b1);

        // Full cond x flags sweep, branches back to back.
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                br_valid = 1; br_type = 2'd3; br_cond = 4'(c);
                step();
                check($sformatf("sweep_f%0h_c%0h", f, c), taken_s, ref_cond(4'(c), 4'(f)));
            end
            br_valid = 0;
        end

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(63) == 0);
            flush        = ($urandom_range(15) == 0);
            ex_set_flags = $urandom_range(1);
            {ex_negative, ex_zero, ex_overflow, ex_carry_out} = 4'($urandom_range(15));
            br_valid     = ($urandom_range(3) != 0);
            br_type      = 2'($urandom_range(3));
            br_cond      = 4'($urandom_range(15));
            cbz_data     = ($urandom_range(3) == 0) ? 64'd0 : {$urandom, $urandom};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
